// File: rtl/sti_load_ctrl.sv
// Load controller for a parallel-in serializer: buffers host words in a 4-deep FIFO
// and sequences load / gap / shift / end strobes toward the serializer.
module sti_load_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic [1:0]  in_length,
  input  logic        in_fill,
  input  logic        in_msb,
  input  logic        in_low,
  input  logic        in_end,
  output logic        load,
  output logic [15:0] pi_data,
  output logic [1:0]  pi_length,
  output logic        pi_fill,
  output logic        pi_msb,
  output logic        pi_low,
  output logic        pi_end,
  input  logic        so_valid,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, LOAD, GAP, SHIFT, END} state_t;

  state_t      state;
  logic [20:0] mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;
  logic        end_pending;
  logic [20:0] hold;
  logic [4:0]  bit_cnt;

  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        fifo_wr;
  logic        start;
  logic        err_cond;
  logic [20:0] in_word;
  logic [20:0] head_word;

  assign full     = (count == 3'd4);
  assign empty    = (count == 3'd0);
  assign in_ready = !full && !end_pending;
  assign push     = in_valid && in_ready;
  assign in_word  = {in_data, in_length, in_fill, in_msb, in_low};

  // An empty FIFO is bypassed so a word accepted while idle loads on the very next cycle.
  assign head_word = empty ? in_word : mem[rd_ptr];
  assign start     = (!empty || push) &&
                     ((state == IDLE) || ((state == SHIFT) && (bit_cnt == 5'd0)));
  assign pop       = start && !empty;
  assign fifo_wr   = push && !(start && empty);

  assign err_cond = ((state == SHIFT) && !so_valid) ||
                    ((state == IDLE) && so_valid) ||
                    (in_valid && !in_ready && end_pending);

  assign {pi_data, pi_length, pi_fill, pi_msb, pi_low} = hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (fifo_wr) begin
        mem[wr_ptr] <= in_word;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      count <= count + {2'd0, fifo_wr} - {2'd0, pop};
    end
  end

  // The holding register feeds the serializer directly, so it only changes on entry to LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      hold        <= 21'd0;
      bit_cnt     <= 5'd0;
      end_pending <= 1'b0;
      load        <= 1'b0;
      pi_end      <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      load   <= 1'b0;
      pi_end <= 1'b0;
      if (in_end) begin
        end_pending <= 1'b1;
      end
      if (err_cond) begin
        err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            hold  <= head_word;
            load  <= 1'b1;
            state <= LOAD;
          end else if (end_pending && empty) begin
            pi_end <= 1'b1;
            done   <= 1'b1;
            state  <= END;
          end
        end
        LOAD: state <= GAP;
        GAP: begin
          bit_cnt <= {pi_length, 3'b111};
          state   <= SHIFT;
        end
        SHIFT: begin
          if (bit_cnt == 5'd0) begin
            if (start) begin
              hold  <= head_word;
              load  <= 1'b1;
              state <= LOAD;
            end else begin
              state <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt - 5'd1;
          end
        end
        END: state <= END;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
